hex_page_scheduler: RTL and testbench

HEX_PAGE_SCHEDULER -- requirements
Module: hex_page_scheduler

---
 rtl/hex_page_scheduler_if.sv | 24 ++
 rtl/hex_page_scheduler.sv | 109 ++++++++++
 tb/tb_hex_page_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_page_scheduler_if.sv
// rtl/hex_page_scheduler_if.sv - page store, rotation control and override bus for hex_page_scheduler
interface hex_page_scheduler_if;
    logic        wr_en;
    logic [1:0]  wr_page;
    logic [23:0] wr_data;
    logic [3:0]  page_en;
    logic        freeze;
    logic        ovr_valid;
    logic [23:0] ovr_data;
    logic        ovr_ready;
    logic [23:0] hex_codes;
    logic [1:0]  page_idx;
    logic        ovr_active;

    modport master (
        output wr_en, wr_page, wr_data, page_en, freeze, ovr_valid, ovr_data,
        input  ovr_ready, hex_codes, page_idx, ovr_active
    );

    modport slave (
        input  wr_en, wr_page, wr_data, page_en, freeze, ovr_valid, ovr_data,
        output ovr_ready, hex_codes, page_idx, ovr_active
    );
endinterface

// File: rtl/hex_page_scheduler.sv
// rtl/hex_page_scheduler.sv - four-page hex display rotator with dwell timer, freeze and one-shot override
module hex_page_scheduler #(
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input logic                  Clk,
    input logic                  Reset,
    hex_page_scheduler_if.slave  bus
);

    localparam logic [0:0]  ST_ROTATE   = 1'b0;
    localparam logic [0:0]  ST_OVERRIDE = 1'b1;
    localparam logic [31:0] LAST_COUNT  = 32'(DWELL_CYCLES - 32'd1);

    logic [23:0] r_pages [4];
    logic [23:0] r_ovr_buf;
    logic [23:0] r_hex;
    logic [31:0] r_cnt;
    logic [1:0]  r_page_idx;
    logic [0:0]  r_state;
    logic        r_ovr_active;

    logic        w_expire;
    logic        w_any_en;
    logic        w_accept;
    logic [1:0]  w_next_en_idx;
    logic [0:0]  w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic [1:0]  w_idx_nxt;
    logic [23:0] w_page_data;
    logic [23:0] w_hex_nxt;

    // First enabled page after idx in wrap-around order; idx itself when no other page is enabled.
    function automatic logic [1:0] f_next_page(input logic [1:0] idx, input logic [3:0] en);
        logic [1:0] r;
        logic [1:0] c;
        r = idx;
        for (int k = 3; k >= 1; k--) begin
            c = idx + 2'(k);
            if (en[c]) r = c;
        end
        return r;
    endfunction

    assign w_expire      = (r_cnt == LAST_COUNT);
    assign w_any_en      = (bus.page_en != 4'b0000);
    assign w_next_en_idx = f_next_page(r_page_idx, bus.page_en);
    assign bus.ovr_ready = (r_state == ST_ROTATE) && !Reset;
    assign w_accept      = bus.ovr_valid && bus.ovr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 32'd1;
        w_idx_nxt   = r_page_idx;
        if (r_state == ST_ROTATE) begin
            if (w_accept) begin
                w_state_nxt = ST_OVERRIDE;
                w_cnt_nxt   = 32'd0;
            end else if (w_any_en && !bus.page_en[r_page_idx]) begin
                w_idx_nxt = w_next_en_idx;
                w_cnt_nxt = 32'd0;
            end else if (bus.freeze) begin
                w_cnt_nxt = r_cnt;
            end else if (w_expire) begin
                w_idx_nxt = w_next_en_idx;
                w_cnt_nxt = 32'd0;
            end
        end else if (w_expire) begin
            w_state_nxt = ST_ROTATE;
            w_cnt_nxt   = 32'd0;
        end
    end

    // Forward a same-edge write so the display never shows a stale page for a cycle.
    assign w_page_data = (bus.wr_en && (bus.wr_page == w_idx_nxt)) ? bus.wr_data : r_pages[w_idx_nxt];

    always_comb begin
        w_hex_nxt = 24'h000000;
        if (w_state_nxt == ST_OVERRIDE) begin
            w_hex_nxt = w_accept ? bus.ovr_data : r_ovr_buf;
        end else if (w_any_en) begin
            w_hex_nxt = w_page_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) r_pages[i] <= 24'h000000;
            r_ovr_buf    <= 24'h000000;
            r_hex        <= 24'h000000;
            r_cnt        <= 32'd0;
            r_page_idx   <= 2'd0;
            r_state      <= ST_ROTATE;
            r_ovr_active <= 1'b0;
        end else begin
            if (bus.wr_en) r_pages[bus.wr_page] <= bus.wr_data;
            if (w_accept) r_ovr_buf <= bus.ovr_data;
            r_hex        <= w_hex_nxt;
            r_cnt        <= w_cnt_nxt;
            r_page_idx   <= w_idx_nxt;
            r_state      <= w_state_nxt;
            r_ovr_active <= (w_state_nxt == ST_OVERRIDE);
        end
    end

    assign bus.hex_codes  = r_hex;
    assign bus.page_idx   = r_page_idx;
    assign bus.ovr_active = r_ovr_active;

endmodule

// File: tb/tb_hex_page_scheduler.sv
// tb/tb_hex_page_scheduler.sv - self-checking bench for hex_page_scheduler with DWELL_CYCLES=4
module tb_hex_page_scheduler;

    localparam int DW = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    hex_page_scheduler_if bus ();

    hex_page_scheduler #(.DWELL_CYCLES(DW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Reference model state, advanced once per clock from the inputs held before the edge.
    int          m_cnt = 0;
    int          m_idx = 0;
    bit          m_ovr = 1'b0;
    logic [23:0] m_pages [4] = '{default: 24'h0};
    logic [23:0] m_buf = 24'h0;
    logic [23:0] m_hex = 24'h0;
    bit          m_act = 1'b0;

    function automatic int next_page(int cur, logic [3:0] en);
        for (int j = 1; j <= 4; j++) begin
            if (en[(cur + j) % 4]) return (cur + j) % 4;
        end
        return cur;
    endfunction

    function automatic logic [23:0] pg_val(int p);
        logic [3:0] d;
        d = 4'(p + 1);
        return {6{d}};
    endfunction

    task automatic tick();
        logic [23:0] pg [4];
        logic [23:0] bf;
        logic [23:0] hx;
        int cnt;
        int idx;
        bit ovr;
        cnt = m_cnt; idx = m_idx; ovr = m_ovr; bf = m_buf;
        for (int i = 0; i < 4; i++) pg[i] = m_pages[i];
        if (Reset) begin
            cnt = 0; idx = 0; ovr = 0; bf = 24'h0;
            for (int i = 0; i < 4; i++) pg[i] = 24'h0;
            hx = 24'h0;
        end else begin
            if (bus.wr_en) pg[bus.wr_page] = bus.wr_data;
            if (!ovr && bus.ovr_valid) begin
                ovr = 1; bf = bus.ovr_data; cnt = 0;
            end else if (!ovr) begin
                if (bus.page_en != 0 && !bus.page_en[idx]) begin
                    idx = next_page(idx, bus.page_en); cnt = 0;
                end else if (!bus.freeze) begin
                    if (cnt == DW - 1) begin
                        cnt = 0; idx = next_page(idx, bus.page_en);
                    end else cnt++;
                end
            end else begin
                if (cnt == DW - 1) begin
                    ovr = 0; cnt = 0;
                end else cnt++;
            end
            hx = ovr ? bf : ((bus.page_en != 0) ? pg[idx] : 24'h0);
        end
        @(posedge Clk);
        m_cnt = cnt; m_idx = idx; m_ovr = ovr; m_buf = bf; m_hex = hx; m_act = ovr;
        for (int i = 0; i < 4; i++) m_pages[i] = pg[i];
        #1;
    endtask

    task automatic test_reset();
        bus.wr_en = 1; bus.wr_page = 2'd1; bus.wr_data = 24'hABCABC;
        bus.ovr_valid = 1; bus.ovr_data = 24'h123123;
        bus.page_en = 4'hF; bus.freeze = 0;
        Reset = 1;
        tick(); tick();
        n_checks++; if (bus.hex_codes !== 24'h0) begin n_fail++; $display("FAIL reset_hex got=%h exp=000000", bus.hex_codes); end
        n_checks++; if (bus.page_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", bus.page_idx); end
        n_checks++; if (bus.ovr_active !== 1'b0) begin n_fail++; $display("FAIL reset_act got=%b exp=0", bus.ovr_active); end
        n_checks++; if (bus.ovr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_hi got=%b exp=0", bus.ovr_ready); end
        bus.wr_en = 0; bus.ovr_valid = 0;
        Reset = 0;
        #1;
        n_checks++; if (bus.ovr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_lo got=%b exp=1", bus.ovr_ready); end
    endtask

    task automatic test_rotation();
        bus.page_en = 4'hF; bus.freeze = 1;
        for (int p = 0; p < 4; p++) begin
            bus.wr_en = 1; bus.wr_page = 2'(p); bus.wr_data = pg_val(p);
            tick();
        end
        bus.wr_en = 0; bus.freeze = 0;
        n_checks++; if (bus.hex_codes !== pg_val(0)) begin n_fail++; $display("FAIL rot_start got=%h exp=%h", bus.hex_codes, pg_val(0)); end
        for (int t = 1; t <= 17; t++) begin
            tick();
            n_checks++; if (bus.page_idx !== 2'((t / 4) % 4)) begin n_fail++; $display("FAIL rot_idx t=%0d got=%0d exp=%0d", t, bus.page_idx, (t / 4) % 4); end
            n_checks++; if (bus.hex_codes !== pg_val((t / 4) % 4)) begin n_fail++; $display("FAIL rot_hex t=%0d got=%h exp=%h", t, bus.hex_codes, pg_val((t / 4) % 4)); end
        end
    endtask

    task automatic test_skip_pages();
        int budget;
        bus.page_en = 4'b0101;
        for (int t = 0; t < 12; t++) begin
            tick();
            n_checks++; if (bus.page_idx[0] !== 1'b0 || bus.page_idx !== 2'(m_idx)) begin n_fail++; $display("FAIL skip_idx got=%0d exp=%0d", bus.page_idx, m_idx); end
            n_checks++; if (bus.hex_codes !== m_hex) begin n_fail++; $display("FAIL skip_hex got=%h exp=%h", bus.hex_codes, m_hex); end
        end
        budget = 0;
        while (bus.page_idx !== 2'd2 && budget < 20) begin tick(); budget++; end
        n_checks++; if (bus.page_idx !== 2'd2) begin n_fail++; $display("FAIL skip_reach2 got=%0d exp=2", bus.page_idx); end
        bus.page_en = 4'b0001;
        tick();
        n_checks++; if (bus.page_idx !== 2'd0) begin n_fail++; $display("FAIL skip_disable_idx got=%0d exp=0", bus.page_idx); end
        n_checks++; if (bus.hex_codes !== pg_val(0)) begin n_fail++; $display("FAIL skip_disable_hex got=%h exp=%h", bus.hex_codes, pg_val(0)); end
    endtask

    task automatic test_override();
        int budget;
        bus.page_en = 4'hF;
        budget = 0;
        while (bus.page_idx !== 2'd1 && budget < 20) begin tick(); budget++; end
        n_checks++; if (bus.page_idx !== 2'd1) begin n_fail++; $display("FAIL ovr_reach1 got=%0d exp=1", bus.page_idx); end
        n_checks++; if (bus.ovr_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_ready_pre got=%b exp=1", bus.ovr_ready); end
        bus.ovr_valid = 1; bus.ovr_data = 24'hABCDEF;
        tick();
        bus.ovr_valid = 0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            if (k <= 3) begin
                n_checks++; if (bus.hex_codes !== 24'hABCDEF || bus.ovr_active !== 1'b1 || bus.ovr_ready !== 1'b0) begin
                    n_fail++; $display("FAIL ovr_shown k=%0d got=%h/%b/%b exp=abcdef/1/0", k, bus.hex_codes, bus.ovr_active, bus.ovr_ready); end
                n_checks++; if (bus.page_idx !== 2'd1) begin n_fail++; $display("FAIL ovr_idx k=%0d got=%0d exp=1", k, bus.page_idx); end
            end else if (k <= 7) begin
                n_checks++; if (bus.hex_codes !== pg_val(1) || bus.ovr_active !== 1'b0 || bus.ovr_ready !== 1'b1) begin
                    n_fail++; $display("FAIL ovr_resume k=%0d got=%h/%b/%b exp=%h/0/1", k, bus.hex_codes, bus.ovr_active, bus.ovr_ready, pg_val(1)); end
            end else begin
                n_checks++; if (bus.page_idx !== 2'd2) begin n_fail++; $display("FAIL ovr_next got=%0d exp=2", bus.page_idx); end
            end
        end
    endtask

    task automatic test_freeze();
        tick();
        bus.freeze = 1;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_checks++; if (bus.page_idx !== 2'd2 || bus.hex_codes !== pg_val(2)) begin
                n_fail++; $display("FAIL frz_hold t=%0d got=%0d/%h exp=2/%h", t, bus.page_idx, bus.hex_codes, pg_val(2)); end
        end
        bus.freeze = 0;
        tick(); tick();
        n_checks++; if (bus.page_idx !== 2'd2) begin n_fail++; $display("FAIL frz_remain got=%0d exp=2", bus.page_idx); end
        tick();
        n_checks++; if (bus.page_idx !== 2'd3 || bus.hex_codes !== pg_val(3)) begin
            n_fail++; $display("FAIL frz_advance got=%0d/%h exp=3/%h", bus.page_idx, bus.hex_codes, pg_val(3)); end
    endtask

    task automatic test_reset_in_override();
        bus.ovr_valid = 1; bus.ovr_data = 24'h5A5A5A;
        tick();
        bus.ovr_valid = 0;
        n_checks++; if (bus.ovr_active !== 1'b1) begin n_fail++; $display("FAIL rio_enter got=%b exp=1", bus.ovr_active); end
        tick();
        Reset = 1;
        tick();
        n_checks++; if (bus.hex_codes !== 24'h0 || bus.page_idx !== 2'd0) begin
            n_fail++; $display("FAIL rio_clear got=%h/%0d exp=000000/0", bus.hex_codes, bus.page_idx); end
        n_checks++; if (bus.ovr_active !== 1'b0 || bus.ovr_ready !== 1'b0) begin
            n_fail++; $display("FAIL rio_flags got=%b/%b exp=0/0", bus.ovr_active, bus.ovr_ready); end
        Reset = 0;
        #1;
        n_checks++; if (bus.ovr_ready !== 1'b1) begin n_fail++; $display("FAIL rio_ready got=%b exp=1", bus.ovr_ready); end
        tick();
        n_checks++; if (bus.hex_codes !== 24'h0 || bus.ovr_active !== 1'b0) begin
            n_fail++; $display("FAIL rio_after got=%h/%b exp=000000/0", bus.hex_codes, bus.ovr_active); end
    endtask

    task automatic test_live_write();
        bus.page_en = 4'hF; bus.freeze = 1;
        bus.wr_en = 1; bus.wr_page = 2'd0; bus.wr_data = 24'h123456;
        tick();
        n_checks++; if (bus.hex_codes !== 24'h123456 || bus.page_idx !== 2'd0) begin
            n_fail++; $display("FAIL live_write got=%h/%0d exp=123456/0", bus.hex_codes, bus.page_idx); end
        bus.wr_page = 2'd1; bus.wr_data = 24'hABABAB;
        tick();
        bus.wr_en = 0;
        n_checks++; if (bus.hex_codes !== 24'h123456) begin n_fail++; $display("FAIL live_other got=%h exp=123456", bus.hex_codes); end
        bus.freeze = 0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            Reset         = ($urandom_range(0, 99) < 2);
            bus.wr_en     = ($urandom_range(0, 99) < 30);
            bus.wr_page   = 2'($urandom_range(0, 3));
            bus.wr_data   = 24'($urandom);
            bus.page_en   = ($urandom_range(0, 99) < 10) ? 4'h0 : 4'($urandom_range(0, 15));
            bus.freeze    = ($urandom_range(0, 99) < 20);
            bus.ovr_valid = ($urandom_range(0, 99) < 10);
            bus.ovr_data  = 24'($urandom);
            tick();
            n_checks++; if (bus.page_idx !== 2'(m_idx)) begin n_fail++; $display("FAIL rnd_idx t=%0d got=%0d exp=%0d", t, bus.page_idx, m_idx); end
            n_checks++; if (bus.hex_codes !== m_hex) begin n_fail++; $display("FAIL rnd_hex t=%0d got=%h exp=%h", t, bus.hex_codes, m_hex); end
            n_checks++; if (bus.ovr_active !== m_act) begin n_fail++; $display("FAIL rnd_act t=%0d got=%b exp=%b", t, bus.ovr_active, m_act); end
            n_checks++; if (bus.ovr_ready !== (!m_ovr && !Reset)) begin n_fail++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, bus.ovr_ready, (!m_ovr && !Reset)); end
        end
        Reset = 0;
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_page = 0; bus.wr_data = 0;
        bus.page_en = 0; bus.freeze = 0; bus.ovr_valid = 0; bus.ovr_data = 0;
        test_reset();
        test_rotation();
        test_skip_pages();
        test_override();
        test_freeze();
        test_reset_in_override();
        test_live_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
